// File: rtl/fork_join_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fork_join_ctrl
// Purpose  : Fork/join controller. One accepted start launches up to N_CH
//            timed channels; each counts down its own duration and emits a
//            done pulse. A single join_done pulse fires when the selected
//            join condition (all / any / none) is met.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   start_i        launch request, honoured only while ready_o=1
//   mode_i[1:0]    00 join-all, 01 join-any, 10 join-none, 11 join-all
//   dur_i          per-channel duration, channel i at [i*CNT_W +: CNT_W],
//                  0 = channel not launched
//   ready_o        controller idle, start will be accepted
//   ch_busy_o      channel i counting
//   ch_done_o      one-cycle pulse when channel i finishes
//   join_done_o    one-cycle pulse when the join condition is met
//   join_cycles_o  cycles from accept to join, held until the next join
//   start_err_o    one-cycle pulse for a start seen while busy
// ============================================================================
module fork_join_ctrl #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [1:0]              mode_i,
    input  logic [N_CH*CNT_W-1:0]   dur_i,
    output logic                    ready_o,
    output logic [N_CH-1:0]         ch_busy_o,
    output logic [N_CH-1:0]         ch_done_o,
    output logic                    join_done_o,
    output logic [CNT_W-1:0]        join_cycles_o,
    output logic                    start_err_o
);

    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [1:0]       C_MODE_ANY  = 2'b01;
    localparam logic [1:0]       C_MODE_NONE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    mode_q, mode_d;
    logic [N_CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]              cc_q, cc_d;
    logic [N_CH-1:0]               ch_done_q, ch_done_d;
    logic                          join_done_q, join_done_d;
    logic [CNT_W-1:0]              join_cycles_q, join_cycles_d;
    logic                          start_err_q, start_err_d;

    logic [N_CH-1:0]               w_busy;       // counter nonzero
    logic [N_CH-1:0]               w_finish;     // counter reaches 0 at this edge
    logic [N_CH-1:0]               w_busy_next;  // still counting after this edge
    logic                          w_join;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_busy[i]   = (cnt_q[i] != '0);
            w_finish[i] = (cnt_q[i] == C_ONE);
        end
        w_busy_next = w_busy & ~w_finish;
    end

    // Join condition while in RUN. With nothing launched the join is taken on
    // the first RUN edge regardless of mode. Join-all fires on the edge where
    // the last counter expires, join-any on the edge where the first expires.
    always_comb begin
        w_join = 1'b0;
        if ((mode_q == C_MODE_NONE) || !(|w_busy)) begin
            w_join = 1'b1;
        end else if (mode_q == C_MODE_ANY) begin
            w_join = |w_finish;
        end else begin
            w_join = !(|w_busy_next);
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cc_d          = cc_q;
        join_done_d   = 1'b0;
        join_cycles_d = join_cycles_q;
        ch_done_d     = w_finish;
        start_err_d   = start_i && (state_q != S_IDLE);
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = w_busy[i] ? (cnt_q[i] - C_ONE) : '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    cc_d    = '0;
                    state_d = S_RUN;
                    for (int i = 0; i < N_CH; i++) begin
                        cnt_d[i] = dur_i[i*CNT_W +: CNT_W];
                    end
                end
            end
            S_RUN: begin
                cc_d = cc_q + C_ONE;
                if (w_join) begin
                    join_done_d = 1'b1;
                    // cc_q+1 is the edge count since accept at this edge.
                    if ((mode_q == C_MODE_NONE) || !(|w_busy)) begin
                        join_cycles_d = '0;
                    end else begin
                        join_cycles_d = cc_q + C_ONE;
                    end
                    state_d = (|w_busy_next) ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                cc_d = cc_q + C_ONE;
                if (!(|w_busy_next)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mode_q        <= 2'b00;
            cnt_q         <= '0;
            cc_q          <= '0;
            ch_done_q     <= '0;
            join_done_q   <= 1'b0;
            join_cycles_q <= '0;
            start_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            cc_q          <= cc_d;
            ch_done_q     <= ch_done_d;
            join_done_q   <= join_done_d;
            join_cycles_q <= join_cycles_d;
            start_err_q   <= start_err_d;
        end
    end

    assign ready_o       = (state_q == S_IDLE);
    assign ch_busy_o     = w_busy;
    assign ch_done_o     = ch_done_q;
    assign join_done_o   = join_done_q;
    assign join_cycles_o = join_cycles_q;
    assign start_err_o   = start_err_q;

endmodule
`default_nettype wire

// File: doc/fork_join_ctrl.md
Name: fork_join_ctrl

Overview:
- Synthesizable fork/join controller. One `start` launches up to N_CH parallel timed jobs ("threads").
- Each channel counts down its own duration. Channels that finish emit per-channel done pulses.
- A single `join_done` pulse fires according to a selectable join mode: join-all, join-any or join-none.
- Serves as the hardware dispatcher for parallel sub-sequences in the test infrastructure; a parent FSM waits on `join_done` and `ready`.

Parameters:
- N_CH, 4, number of parallel channels (1..16).
- CNT_W, 8, width of each duration and of the join cycle count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  launch request; sampled only when ready=1.
- mode  in  2  join mode: 00 join-all, 01 join-any, 10 join-none, 11 reserved (behaves as join-all).
- dur  in  N_CH*CNT_W  per-channel duration in cycles; channel i uses bits [i*CNT_W +: CNT_W]; 0 = channel not launched.
- ready  out  1  controller idle, start accepted.
- ch_busy  out  N_CH  channel i counting.
- ch_done  out  N_CH  one-cycle pulse when channel i finishes.
- join_done  out  1  one-cycle pulse when the join condition is met.
- join_cycles  out  CNT_W  cycles from accept to join; latched when join_done fires, held until the next join.
- start_err  out  1  one-cycle pulse when start=1 while ready=0; that start is ignored.

Behaviour:
- Clocking: single clock; reset is asynchronous and active-high.
- Reset values: ready=1; ch_busy=0; ch_done=0; join_done=0; join_cycles=0; start_err=0; FSM=IDLE; all counters=0.
- Reset mid-operation aborts all channels with no pulses.
- FSM states:
  - IDLE: ready=1.
  - RUN: join condition pending.
  - DRAIN: join fired, channels still running.
- Accept: start=1 in IDLE at edge T.
  - mode and dur are captured.
  - Counter i loads dur_i, and ch_busy_i=1 for every dur_i!=0.
  - Cycle counter cc clears to 0.
  - FSM goes to RUN, ready=0.
- Channel timing:
  - The counter decrements at each edge while nonzero.
  - At edge T+dur_i the counter reaches 0: ch_busy_i drops, and ch_done_i is high for exactly the cycle after edge T+dur_i.
  - ch_busy_i is high from T+1 through T+dur_i inclusive, i.e. dur_i cycles.
- cc increments each edge while not IDLE. It cannot overflow, since max duration is 2^CNT_W-1.
- Join condition, evaluated at each edge in RUN, using registered outputs:
  - join-all: the edge where the last launched channel finishes. join_done coincides with that ch_done. join_cycles = max dur.
  - join-any: the edge where the first channel finishes. Simultaneous finishes give a single join_done pulse. join_cycles = min nonzero dur.
  - join-none: join_done high in the cycle after T (edge T+1 registers it), independent of durations. join_cycles = 0.
- After join:
  - If any channel is still busy, go to DRAIN. Channels keep running and keep emitting ch_done; no further join_done.
  - When none are busy, go to IDLE.
- Return to ready: ready=1 in the same cycle the last ch_done is high. A start in that cycle is accepted.
- All durations 0: no channel launched, no ch_done. join_done is high the cycle after T in every mode, join_cycles=0, and ready returns to 1 in that same cycle.
- start while ready=0: start_err pulses one cycle; state is unchanged.
- join_done fires exactly once per accepted start. ch_done_i fires exactly once per launched channel.

Test Plan:
- join-none, dur0=20, dur1=30, others 0, start at T:
  - join_done at T+1, join_cycles=0.
  - ch_done0 at T+20, ch_done1 at T+30.
  - ready=1 at T+30.
- join-all, dur={5,9,2,0}:
  - ch_done pulses at T+5, T+9, T+2; none for ch3.
  - join_done at T+9 with join_cycles=9; ready at T+9.
- join-any, dur={7,3,3,12}:
  - A single join_done at T+3 with join_cycles=3; ch_done1 and ch_done2 both at T+3.
  - Channels 0 and 3 continue: ch_done0 at T+7, ch_done3 at T+12; ready at T+12; no second join_done.
- Back-to-back and error:
  - Start during DRAIN → start_err pulse, no effect.
  - Start in the ready-return cycle → accepted; a new join follows.
- mode=11 with dur={4,1,0,0} → behaves as join-all: join_done at T+4.
- All dur=0 → join_done at T+1, no ch_done.
- Reset mid-run: join-all with dur={50,…}, assert rst at T+10 → all outputs reset immediately; ready=1; no join_done or ch_done afterwards.
